// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Traffic-light sequencing core. Cycles GREEN -> YELLOW -> RED
//                on a 1 s tick, shows the remaining seconds on a 7-segment
//                digit, drives a buzzer square wave during RED, shortens GREEN
//                on a pedestrian request and offers a flashing-yellow night
//                mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
  parameter int CLK_DIV   = 10000000,
  parameter int T_GREEN   = 5,
  parameter int T_YELLOW  = 2,
  parameter int T_RED     = 5,
  parameter int PED_SHORT = 2,
  parameter int BEEP_HALF = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night,
  output logic       led_r,
  output logic       led_g,
  output logic       led_y,
  output logic       pwm_out,
  output logic [6:0] seg,
  output logic [1:0] state
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BEEP_HALF > 0) ? $clog2(BEEP_HALF + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_HALF - 1);

  localparam logic [3:0] DUR_GREEN  = 4'(T_GREEN);
  localparam logic [3:0] DUR_YELLOW = 4'(T_YELLOW);
  localparam logic [3:0] DUR_RED    = 4'(T_RED);
  localparam logic [3:0] PED_REMAIN = 4'(PED_SHORT);

  // Encoding matches the debug state output directly
  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  logic          ped_s1;
  logic          ped_s2;
  logic          ped_d;
  logic          ped_rise;
  logic          night_s1;
  logic          night_s2;

  state_t        cur_state;
  logic [3:0]    remain;
  logic          ped_pend;
  logic          blink;

  logic [BW-1:0] beep_cnt;
  logic          beep_lvl;

  // --------------------------------------------------------------------------
  // 7-segment decode, active-high, seg[0]=a .. seg[6]=g
  // --------------------------------------------------------------------------
  function automatic logic [6:0] digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // One-second prescaler; tick is high for the last count of each second
  // --------------------------------------------------------------------------
  assign tick = (presc == PRESC_LAST);

  // Free-running prescaler that wraps on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Input synchronizers; ped_d holds the previous synchronized level so a
  // held button only registers once
  // --------------------------------------------------------------------------
  // Two-stage synchronizers plus the pedestrian edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1   <= 1'b0;
      ped_s2   <= 1'b0;
      ped_d    <= 1'b0;
      night_s1 <= 1'b0;
      night_s2 <= 1'b0;
    end else begin
      ped_s1   <= ped_req;
      ped_s2   <= ped_s1;
      ped_d    <= ped_s2;
      night_s1 <= night;
      night_s2 <= night_s1;
    end
  end

  assign ped_rise = ped_s2 & ~ped_d;

  // --------------------------------------------------------------------------
  // Main sequencer. Night mode has priority, then the pedestrian shortener,
  // then normal countdown. The pending flag is only consumed on a tick, so a
  // request registered on the same edge as a tick acts on the following one.
  // --------------------------------------------------------------------------
  // Lamp state, seconds remaining, pedestrian pending flag and flash phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_GREEN;
      remain    <= DUR_GREEN;
      ped_pend  <= 1'b0;
      blink     <= 1'b0;
    end else begin
      // Requests outside GREEN are dropped; clearing below takes precedence
      if (ped_rise && (cur_state == ST_GREEN)) begin
        ped_pend <= 1'b1;
      end

      if (tick) begin
        if (night_s2 && (cur_state != ST_FLASH)) begin
          cur_state <= ST_FLASH;
          blink     <= 1'b1;
          ped_pend  <= 1'b0;
        end else if (cur_state == ST_FLASH) begin
          if (night_s2) begin
            blink <= ~blink;
          end else begin
            // Leaving night mode always resumes through a full RED
            cur_state <= ST_RED;
            remain    <= DUR_RED;
            blink     <= 1'b0;
          end
        end else if ((cur_state == ST_GREEN) && ped_pend &&
                     (remain > PED_REMAIN)) begin
          remain <= PED_REMAIN;
        end else if (remain > 4'd1) begin
          remain <= remain - 4'd1;
        end else begin
          case (cur_state)
            ST_GREEN: begin
              cur_state <= ST_YELLOW;
              remain    <= DUR_YELLOW;
              ped_pend  <= 1'b0;
            end
            ST_YELLOW: begin
              cur_state <= ST_RED;
              remain    <= DUR_RED;
            end
            ST_RED: begin
              cur_state <= ST_GREEN;
              remain    <= DUR_GREEN;
            end
            default: begin
              cur_state <= ST_RED;
              remain    <= DUR_RED;
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Buzzer: half-period counter that only runs in RED. Outside RED both the
  // counter and the level are held at zero, so every RED entry starts low.
  // --------------------------------------------------------------------------
  // Square-wave generator gated by the RED state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt <= '0;
      beep_lvl <= 1'b0;
    end else if (cur_state != ST_RED) begin
      beep_cnt <= '0;
      beep_lvl <= 1'b0;
    end else if (beep_cnt == BEEP_LAST) begin
      beep_cnt <= '0;
      beep_lvl <= ~beep_lvl;
    end else begin
      beep_cnt <= beep_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from registers only. The buzzer level is masked with the
  // state so it drops on the same edge that leaves RED.
  // --------------------------------------------------------------------------
  // Lamp, segment and buzzer outputs
  always_comb begin
    led_r   = 1'b0;
    led_g   = 1'b0;
    led_y   = 1'b0;
    pwm_out = 1'b0;
    seg     = digit(remain);
    case (cur_state)
      ST_GREEN:  led_g = 1'b1;
      ST_YELLOW: led_y = 1'b1;
      ST_RED: begin
        led_r   = 1'b1;
        pwm_out = beep_lvl;
      end
      default: begin
        led_y = blink;
        seg   = 7'h00;
      end
    endcase
  end

  assign state = cur_state;

endmodule
`default_nettype wire
